// File: rtl/reg_scoreboard_hazard_unit_if.sv
// ID/WB-side bundle of the register scoreboard.
// master drives decode and writeback info; slave is the scoreboard.
interface reg_scoreboard_hazard_unit_if #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int PERF_W   = 16
);
  logic                id_valid;
  logic [ADDR_W-1:0]   id_rs1;
  logic [ADDR_W-1:0]   id_rs2;
  logic                id_rs1_used;
  logic                id_rs2_used;
  logic                id_reg_write;
  logic [ADDR_W-1:0]   id_rd;
  logic                wb_valid;
  logic [ADDR_W-1:0]   wb_rd;
  logic                flush;
  logic                stall_if;
  logic                stall_id;
  logic                bubble_ex;
  logic                issue;
  logic [NUM_REGS-1:0] pending_mask;
  logic [PERF_W-1:0]   stall_cycles;
  logic                wb_underflow;

  modport master (
    output id_valid, id_rs1, id_rs2,
    output id_rs1_used, id_rs2_used,
    output id_reg_write, id_rd,
    output wb_valid, wb_rd, flush,
    input  stall_if, stall_id, bubble_ex,
    input  issue, pending_mask,
    input  stall_cycles, wb_underflow
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2,
    input  id_rs1_used, id_rs2_used,
    input  id_reg_write, id_rd,
    input  wb_valid, wb_rd, flush,
    output stall_if, stall_id, bubble_ex,
    output issue, pending_mask,
    output stall_cycles, wb_underflow
  );
endinterface

// File: rtl/reg_scoreboard_hazard_unit.sv
// ID-stage register scoreboard with saturating in-flight counters.
// Raises stall/bubble on RAW or counter saturation; releases on WB.
module reg_scoreboard_hazard_unit #(
  parameter int NUM_REGS  = 32,
  parameter int ADDR_W    = 5,
  parameter int CNT_W     = 2,
  parameter int WB_BYPASS = 1,
  parameter int ZERO_REG  = 1,
  parameter int PERF_W    = 16
) (
  input logic clk,
  input logic reset,
  reg_scoreboard_hazard_unit_if.slave sb
);

  typedef enum logic {RUN, STALL} state_t;

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [CNT_W-1:0]    c1, c2, cd, cw;
  logic                busy1, busy2, full, haz;
  logic                inc, dec, same, under;
  logic [NUM_REGS-1:0] inc_vec, dec_vec;
  logic [PERF_W-1:0]   stall_cycles;
  logic                wb_underflow;
  logic                count_en;
  state_t              state, nxt;

  always_comb begin
    c1 = cnt[sb.id_rs1];
    c2 = cnt[sb.id_rs2];
    cd = cnt[sb.id_rd];
    cw = cnt[sb.wb_rd];

    busy1 = (c1 != '0);
    if ((WB_BYPASS != 0) && sb.wb_valid &&
        (sb.wb_rd == sb.id_rs1) && (c1 == ONE))
      busy1 = 1'b0;
    if ((ZERO_REG != 0) && (sb.id_rs1 == '0))
      busy1 = 1'b0;

    busy2 = (c2 != '0);
    if ((WB_BYPASS != 0) && sb.wb_valid &&
        (sb.wb_rd == sb.id_rs2) && (c2 == ONE))
      busy2 = 1'b0;
    if ((ZERO_REG != 0) && (sb.id_rs2 == '0))
      busy2 = 1'b0;

    full = sb.id_reg_write && (cd == MAX);
    haz  = sb.id_valid &&
           ((sb.id_rs1_used && busy1) ||
            (sb.id_rs2_used && busy2) || full);
  end

  // register 0 never counts up or down when hardwired
  always_comb begin
    inc = sb.id_valid && !haz && !sb.flush &&
          sb.id_reg_write &&
          !((ZERO_REG != 0) && (sb.id_rd == '0));
    dec = sb.wb_valid &&
          !((ZERO_REG != 0) && (sb.wb_rd == '0));
    same    = inc && dec && (sb.id_rd == sb.wb_rd);
    under   = dec && !same && (cw == '0);
    inc_vec = inc ? (NUM_REGS'(1) << sb.id_rd) : '0;
    dec_vec = dec ? (NUM_REGS'(1) << sb.wb_rd) : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++)
        cnt[r] <= '0;
      wb_underflow <= 1'b0;
    end else if (sb.flush) begin
      for (int r = 0; r < NUM_REGS; r++)
        cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (inc_vec[r] && !dec_vec[r])
          cnt[r] <= cnt[r] + ONE;
        else if (dec_vec[r] && !inc_vec[r] &&
                 (cnt[r] != '0))
          cnt[r] <= cnt[r] - ONE;
      end
      if (under)
        wb_underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= RUN;
      stall_cycles <= '0;
    end else begin
      state <= nxt;
      if (count_en && (stall_cycles != '1))
        stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end

  always_comb begin
    nxt = RUN;
    if (!sb.flush && haz)
      nxt = STALL;
  end

  always_comb begin
    count_en     = (state == STALL) && (nxt == STALL);
    sb.stall_if  = reset && haz;
    sb.stall_id  = reset && haz;
    sb.bubble_ex = reset && haz;
    sb.issue     = reset && sb.id_valid &&
                   !haz && !sb.flush;
    for (int r = 0; r < NUM_REGS; r++)
      sb.pending_mask[r] = (cnt[r] != '0);
    sb.stall_cycles = stall_cycles;
    sb.wb_underflow = wb_underflow;
  end

endmodule
